// File: rtl/draw_scheduler_pkg.sv
// Shared widths, state encoding and defaults for the breakout draw scheduler.
package draw_scheduler_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  localparam int DEFAULT_FRAME_TICKS = 833334;
  localparam int DEFAULT_TIMEOUT     = 4096;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN      = 3'd1,
    WAIT      = 3'd2,
    NEXT      = 3'd3,
    FRAME_END = 3'd4
  } sched_state_t;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running frame period counter; frame_tick pulses for one cycle on each wrap,
// first pulse FRAME_TICKS cycles after reset release.
module frame_timer
  import draw_scheduler_pkg::*;
#(
  parameter int FRAME_TICKS = DEFAULT_FRAME_TICKS
) (
  input  logic clock,
  input  logic reset_state,
  output logic frame_tick
);

  localparam int CNT_W = ctr_width(FRAME_TICKS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_TICKS - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clock or posedge reset_state) begin
    if (reset_state) begin
      count      <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (count == LAST);
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Grants the single VGA pixel port to each active drawing client once per frame,
// in index order, with per-client timeout supervision and frame overrun detection.
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int N_CLIENTS   = 3,
  parameter int FRAME_TICKS = DEFAULT_FRAME_TICKS,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic                     clock,
  input  logic                     reset_state,
  input  logic [N_CLIENTS-1:0]     client_active,
  input  logic [N_CLIENTS-1:0]     client_done,
  input  logic [N_CLIENTS-1:0]     client_plot,
  input  logic [X_W*N_CLIENTS-1:0] client_x,
  input  logic [Y_W*N_CLIENTS-1:0] client_y,
  input  logic [C_W*N_CLIENTS-1:0] client_colour,
  output logic [N_CLIENTS-1:0]     client_enable,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [C_W-1:0]           vga_colour,
  output logic                     vga_plot,
  output logic                     frame_done,
  output logic [N_CLIENTS-1:0]     timeout_err,
  output logic                     overrun
);

  localparam int IDX_W = ctr_width(N_CLIENTS);
  localparam int TO_W  = ctr_width(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLIENTS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  sched_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [TO_W-1:0]  to_cnt;
  logic             pending;
  logic             frame_tick;

  frame_timer #(.FRAME_TICKS(FRAME_TICKS)) u_frame_timer (
    .clock       (clock),
    .reset_state (reset_state),
    .frame_tick  (frame_tick)
  );

  always_ff @(posedge clock or posedge reset_state) begin
    if (reset_state) begin
      state         <= IDLE;
      idx           <= '0;
      to_cnt        <= '0;
      pending       <= 1'b0;
      client_enable <= '0;
      frame_done    <= 1'b0;
      timeout_err   <= '0;
      overrun       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // At most one late tick is remembered; the frame restarts straight out of IDLE.
      if (frame_tick && (state != IDLE)) begin
        pending <= 1'b1;
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (frame_tick || pending) begin
            idx     <= '0;
            pending <= 1'b0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (client_active[idx]) begin
            client_enable <= N_CLIENTS'(1) << idx;
            to_cnt        <= '0;
            state         <= WAIT;
          end else if (idx == LAST_IDX) begin
            frame_done <= 1'b1;
            state      <= FRAME_END;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        WAIT: begin
          // A done sampled on the last allowed cycle still counts as a clean finish.
          if (client_done[idx]) begin
            client_enable <= '0;
            state         <= NEXT;
          end else if (to_cnt == TO_LAST) begin
            client_enable    <= '0;
            timeout_err[idx] <= 1'b1;
            state            <= NEXT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        NEXT: begin
          if (idx == LAST_IDX) begin
            frame_done <= 1'b1;
            state      <= FRAME_END;
          end else begin
            idx   <= idx + 1'b1;
            state <= SCAN;
          end
        end
        // frame_done was raised on entry, so it is high exactly while in FRAME_END.
        FRAME_END: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset_state) begin
    if (reset_state) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_x      <= client_x[int'(idx)*X_W +: X_W];
      vga_y      <= client_y[int'(idx)*Y_W +: Y_W];
      vga_colour <= client_colour[int'(idx)*C_W +: C_W];
      vga_plot   <= client_plot[idx] & (state == WAIT);
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: expected grant/release/error/frame events and
// pixels are queued by the stimulus and consumed by a negedge monitor.
module tb_draw_scheduler;

  localparam int K_GRANT = 1, K_RELEASE = 2, K_TERR = 3, K_OVR = 4, K_FD = 5;

  typedef struct {
    int kind;
    int idx;
    int cyc;
    int val;
  } ev_t;

  typedef struct {
    int          cyc;
    logic [17:0] pix;
  } pix_t;

  logic        clock = 1'b0;
  logic        reset_state = 1'b0;
  logic [2:0]  client_active = '0;
  logic [2:0]  client_done = '0;
  logic [2:0]  client_plot = '0;
  logic [23:0] client_x = '0;
  logic [20:0] client_y = '0;
  logic [8:0]  client_colour = '0;
  logic [2:0]  client_enable;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        frame_done;
  logic [2:0]  timeout_err;
  logic        overrun;

  logic [2:0]  ovr_active = '0;
  logic [2:0]  ovr_done = '0;
  logic [2:0]  o_enable;
  logic [7:0]  o_vga_x;
  logic [6:0]  o_vga_y;
  logic [2:0]  o_vga_colour;
  logic        o_vga_plot;
  logic        o_frame_done;
  logic [2:0]  o_terr;
  logic        o_overrun;

  int   cyc;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   delay [3];
  int   age [3];
  logic pix_mode = 1'b0;

  ev_t  exp_q[$];
  ev_t  ovr_q[$];
  pix_t pix_q[$];

  logic [2:0] prev_en [2];
  logic [2:0] prev_te [2];
  logic       prev_ov [2];

  draw_scheduler #(.N_CLIENTS(3), .FRAME_TICKS(100), .TIMEOUT(20)) dut (
    .clock(clock), .reset_state(reset_state),
    .client_active(client_active), .client_done(client_done), .client_plot(client_plot),
    .client_x(client_x), .client_y(client_y), .client_colour(client_colour),
    .client_enable(client_enable), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .frame_done(frame_done), .timeout_err(timeout_err), .overrun(overrun)
  );

  // Long timeout so a client can outlast a frame period and provoke an overrun.
  draw_scheduler #(.N_CLIENTS(3), .FRAME_TICKS(100), .TIMEOUT(256)) dut_ovr (
    .clock(clock), .reset_state(reset_state),
    .client_active(ovr_active), .client_done(ovr_done), .client_plot(3'b000),
    .client_x(24'd0), .client_y(21'd0), .client_colour(9'd0),
    .client_enable(o_enable), .vga_x(o_vga_x), .vga_y(o_vga_y), .vga_colour(o_vga_colour),
    .vga_plot(o_vga_plot), .frame_done(o_frame_done), .timeout_err(o_terr), .overrun(o_overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset_state) begin
    if (reset_state) cyc <= 0;
    else             cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] enc(input ev_t e);
    return {8'(e.kind), 8'(e.idx), 32'(e.cyc), 16'(e.val)};
  endfunction

  task automatic push_ev(input int w, input int kind, input int idx, input int c, input int v);
    ev_t e;
    e = '{kind, idx, c, v};
    if (w == 0) exp_q.push_back(e);
    else        ovr_q.push_back(e);
  endtask

  task automatic push_pix(input int c, input logic [7:0] x, input logic [6:0] y, input logic [2:0] col);
    pix_t p;
    p.cyc = c;
    p.pix = {x, y, col};
    pix_q.push_back(p);
  endtask

  task automatic take(input int w, input ev_t got);
    ev_t e;
    if ((w == 0 && exp_q.size() == 0) || (w == 1 && ovr_q.size() == 0)) begin
      tests_run++;
      tests_failed++;
      $display("FAIL dut%0d unexpected event: got %h expected none", w, enc(got));
    end else begin
      if (w == 0) e = exp_q.pop_front();
      else        e = ovr_q.pop_front();
      check($sformatf("dut%0d event", w), enc(got), enc(e));
    end
  endtask

  task automatic scan(input int w, input logic [2:0] en, input logic fd,
                      input logic [2:0] te, input logic ov);
    for (int i = 0; i < 3; i++) begin
      if (en[i] && !prev_en[w][i]) take(w, '{K_GRANT, i, cyc, 1});
      if (!en[i] && prev_en[w][i]) take(w, '{K_RELEASE, i, cyc, 0});
    end
    if (te != prev_te[w]) take(w, '{K_TERR, 0, cyc, int'(te)});
    if (ov && !prev_ov[w]) take(w, '{K_OVR, 0, cyc, 1});
    if (fd) take(w, '{K_FD, 0, cyc, 1});
    prev_en[w] = en;
    prev_te[w] = te;
    prev_ov[w] = ov;
  endtask

  // Monitor: turns output changes into events and matches them against the queues.
  initial begin
    pix_t p;
    for (int w = 0; w < 2; w++) begin
      prev_en[w] = '0;
      prev_te[w] = '0;
      prev_ov[w] = 1'b0;
    end
    forever begin
      @(negedge clock);
      if (reset_state) begin
        for (int w = 0; w < 2; w++) begin
          prev_en[w] = '0;
          prev_te[w] = '0;
          prev_ov[w] = 1'b0;
        end
      end else begin
        scan(0, client_enable, frame_done, timeout_err, overrun);
        scan(1, o_enable, o_frame_done, o_terr, o_overrun);
        if (vga_plot) begin
          if (pix_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected pixel: got %h at cycle %0d expected none",
                     {vga_x, vga_y, vga_colour}, cyc);
          end else begin
            p = pix_q.pop_front();
            check("pixel", {32'(cyc), 14'd0, vga_x, vga_y, vga_colour}, {32'(p.cyc), 14'd0, p.pix});
          end
        end
      end
    end
  end

  // Client model: pulses done delay[i] cycles after its enable rises; in pixel mode
  // client 1 plots while granted and clients 0/2 plot only while not granted.
  initial begin
    for (int i = 0; i < 3; i++) age[i] = 0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        if (!client_enable[i]) begin
          age[i] = 0;
          client_done[i] = 1'b0;
        end else begin
          client_done[i] = (age[i] == delay[i]);
          age[i]++;
        end
      end
      if (pix_mode) client_plot = {~client_enable[2], client_enable[1], ~client_enable[0]};
      else          client_plot = 3'b000;
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2);
    delay[0] = d0;
    delay[1] = d1;
    delay[2] = d2;
  endtask

  task automatic push_basic(input int t);
    push_ev(0, K_GRANT, 0, t + 2, 1);
    push_ev(0, K_RELEASE, 0, t + 8, 0);
    push_ev(0, K_GRANT, 1, t + 10, 1);
    push_ev(0, K_RELEASE, 1, t + 16, 0);
    push_ev(0, K_GRANT, 2, t + 18, 1);
    push_ev(0, K_RELEASE, 2, t + 24, 0);
    push_ev(0, K_FD, 0, t + 25, 1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {client_enable, vga_x, vga_y, vga_colour, vga_plot, frame_done, timeout_err, overrun}, '0);
  endtask

  initial begin
    set_delays(5, 5, 5);
    #2 reset_state = 1'b1;
    client_active = 3'b111;
    ovr_active    = 3'b001;
    push_basic(100);
    push_ev(1, K_GRANT, 0, 102, 1);
    push_ev(1, K_OVR, 0, 201, 1);
    push_ev(1, K_RELEASE, 0, 252, 0);
    push_ev(1, K_FD, 0, 255, 1);
    push_ev(1, K_GRANT, 0, 258, 1);
    push_ev(1, K_RELEASE, 0, 264, 0);
    push_ev(1, K_FD, 0, 267, 1);
    push_ev(1, K_FD, 0, 304, 1);
    push_ev(1, K_FD, 0, 404, 1);
    push_ev(1, K_FD, 0, 504, 1);
    push_ev(1, K_FD, 0, 604, 1);
    repeat (3) @(negedge clock);
    check_all_zero("reset state");
    reset_state = 1'b0;

    wait_cyc(5);
    check_all_zero("idle after reset");

    // Frame at 200: pixel forwarding from client 1 only.
    wait_cyc(150);
    client_x      = {8'hC3, 8'd37, 8'h5A};
    client_y      = {7'h7F, 7'd100, 7'h11};
    client_colour = {3'b111, 3'b101, 3'b010};
    pix_mode      = 1'b1;
    push_basic(200);
    for (int c = 211; c <= 216; c++) push_pix(c, 8'd37, 7'd100, 3'b101);

    wait_cyc(250);
    pix_mode = 1'b0;
    wait_cyc(251);
    ovr_done = 3'b001;
    wait_cyc(252);
    ovr_done = 3'b000;
    wait_cyc(260);
    ovr_active = 3'b000;
    wait_cyc(263);
    ovr_done = 3'b001;
    wait_cyc(264);
    ovr_done = 3'b000;

    // Frame at 300: client 1 inactive is skipped.
    wait_cyc(290);
    client_active = 3'b101;
    push_ev(0, K_GRANT, 0, 302, 1);
    push_ev(0, K_RELEASE, 0, 308, 0);
    push_ev(0, K_GRANT, 2, 311, 1);
    push_ev(0, K_RELEASE, 2, 317, 0);
    push_ev(0, K_FD, 0, 318, 1);
    wait_cyc(300);
    check("overrun flagged", 64'(o_overrun), 64'd1);

    // Frame at 400: done on the 20th WAIT cycle beats the timeout.
    wait_cyc(390);
    client_active = 3'b001;
    set_delays(19, 5, 5);
    push_ev(0, K_GRANT, 0, 402, 1);
    push_ev(0, K_RELEASE, 0, 422, 0);
    push_ev(0, K_FD, 0, 425, 1);
    wait_cyc(440);
    check("no timeout at boundary", 64'(timeout_err), 64'd0);

    // Frame at 500: client 0 never finishes; client 1 still served.
    wait_cyc(490);
    client_active = 3'b011;
    set_delays(255, 5, 5);
    push_ev(0, K_GRANT, 0, 502, 1);
    push_ev(0, K_RELEASE, 0, 522, 0);
    push_ev(0, K_TERR, 0, 522, 1);
    push_ev(0, K_GRANT, 1, 524, 1);
    push_ev(0, K_RELEASE, 1, 530, 0);
    push_ev(0, K_FD, 0, 532, 1);
    wait_cyc(540);
    check("timeout sticky", 64'(timeout_err), 64'd1);
    check("no overrun main", 64'(overrun), 64'd0);

    // Frame at 600: reset while client 1 is granted.
    wait_cyc(590);
    set_delays(5, 255, 5);
    push_ev(0, K_GRANT, 0, 602, 1);
    push_ev(0, K_RELEASE, 0, 608, 0);
    push_ev(0, K_GRANT, 1, 610, 1);
    wait_cyc(612);
    check("enable before reset", 64'(client_enable), 64'h2);
    #1 reset_state = 1'b1;
    #1 check_all_zero("async reset outputs");
    check("async reset ovr flags", {o_enable, o_overrun, o_terr}, '0);
    client_active = 3'b001;
    set_delays(5, 5, 5);
    push_ev(0, K_GRANT, 0, 102, 1);
    push_ev(0, K_RELEASE, 0, 108, 0);
    push_ev(0, K_FD, 0, 111, 1);
    push_ev(1, K_FD, 0, 104, 1);
    repeat (2) @(negedge clock);
    reset_state = 1'b0;

    wait_cyc(99);
    check("no grant before tick", 64'(client_enable), 64'd0);
    wait_cyc(130);
    check("main queue drained", 64'(exp_q.size()), 64'd0);
    check("ovr queue drained", 64'(ovr_q.size()), 64'd0);
    check("pixel queue drained", 64'(pix_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
